alu_result_queue: RTL and testbench
===================================

# alu_result_queue

Buffers results of the 16-bit ALU (`Out`, `OFL`, `Zero`) for the writeback side and decouples ALU issue from consumer stalls. It sits directly downstream of the ALU. Each accepted result is stored with its flags in a small in-order FIFO and presented to the consumer over a valid/ready handshake. It also keeps a sticky overflow indicator for exception and status logic.

## Interface
- `DEPTH`, default 4: number of entries; must be a power of two, ≥2.
- `W`, default 16: result width; must match the ALU data width.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset; one clock, synchronous, active-low.
- `in_valid` in 1: ALU result on `in_data`/`in_ofl`/`in_zero` is valid this cycle.
- `in_ready` out 1: queue can accept a result; equals `!full`.
- `in_data` in W: ALU `Out`.
- `in_ofl` in 1: ALU `OFL`.
- `in_zero` in 1: ALU `Zero`.
- `out_valid` out 1: head entry valid; equals `!empty`.
- `out_ready` in 1: consumer takes the head this cycle.
- `out_data` out W: head result.
- `out_ofl` out 1: head overflow flag.
- `out_zero` out 1: head zero flag.
- `count` out clog2(DEPTH)+1: number of occupied entries.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `ofl_sticky` out 1: set if any accepted result had `in_ofl=1` since the last clear.
- `clr_sticky` in 1: clears `ofl_sticky`.

## Operation
- Push: occurs when `in_valid && in_ready`. Writes {data, ofl, zero} at the write pointer, then increments the write pointer modulo DEPTH.
- Pop: occurs when `out_valid && out_ready`. Increments the read pointer modulo DEPTH.
- Order is strictly FIFO. Entries are never dropped or reordered.
- Push and pop in the same cycle: both happen and `count` is unchanged.
- Full: `in_ready=0`, so there is no push. A same-cycle pop does not open a slot until the next cycle; there is no pass-through when full.
- Empty: `out_valid=0`. A pop request is ignored. `out_data`/`out_ofl`/`out_zero` are don't-care, and the verification engineer must not check them.
- `in_valid` while `in_ready=0`: the result is not accepted. The upstream side must hold it.
- Pointers carry no extra wrap bit. Occupancy is taken from the `count` register, which is updated by +1, −1 or 0.
- `ofl_sticky` update order:
  - if `clr_sticky` is high, it clears;
  - if the same cycle also has a push with `in_ofl=1`, the set wins and `ofl_sticky=1`;
  - a rejected `in_valid` never sets it.
- The stored `zero` is the ALU's flag, carried unchanged; it is not recomputed.

## Timing
- Reset (rst_n=0 at a clk edge):
  - `count=0`, `empty=1`, `full=0`, `in_ready=1`, `out_valid=0`, `ofl_sticky=0`;
  - pointers are cleared to 0;
  - storage contents are not reset.
- Reset mid-operation discards all entries. Pushes and pops in the reset cycle are ignored.
- Latency: a result pushed at edge N is visible at the head with `out_valid=1` after edge N (no combinational bypass).
- `in_ready`, `out_valid`, `full`, `empty` and `count` are all register-derived, with no combinational path from `in_valid` or `out_ready`.
- `out_data`/`out_ofl`/`out_zero` are read combinationally from storage at the read pointer.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.

## Configuration
- `ALU_RESULT_QUEUE_STATS_EN`
  - Defined: adds outputs `push_cnt` [15:0] (accepted pushes) and `ofl_cnt` [15:0] (accepted pushes with `in_ofl=1`). Both saturate at 16'hFFFF, reset to 0, and are unaffected by `clr_sticky`.
  - Undefined: the ports and their logic are absent, and the rest of the behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - `ALU_W = 16`;
  - typedef `alu_result_t` = {data[ALU_W-1:0], ofl, zero};
  - the queue stores `alu_result_t`.
- One sub-module, `alu_result_mem`: a DEPTH×$bits(alu_result_t) register array with one synchronous write port and one asynchronous read port. Pointers, count, flags and statistics stay in the top level.

## Test plan
- Reset, then push 16'h0001/ofl0, 16'h8000/ofl1, 16'h0000/zero1 with out_ready=0 → count=3, head=16'h0001. Pops then return the three entries in order with their flags, and `ofl_sticky=1`.
- Fill to DEPTH=4 with 16'hA0A0..A0A3 → full=1 and in_ready=0. A 5th push of 16'hFFFF is rejected. Draining yields exactly A0A0..A0A3.
- Hold in_valid=1 and out_ready=1 for 20 cycles with incrementing data 0..19 from one entry of occupancy → count stays 1. The output sequence is 0..19 in order, exercising pointer wrap 4×.
- Issue clr_sticky in the same cycle as a push with ofl=1 → ofl_sticky=1. clr_sticky alone next cycle → 0. A rejected in_valid with ofl=1 while full → ofl_sticky stays 0.
- Assert rst_n=0 with 3 entries held and a simultaneous push → next cycle count=0, empty=1, ofl_sticky=0, out_valid=0.
- With STATS_EN: 70000 accepted pushes, every 2nd with ofl=1 → push_cnt=16'hFFFF (saturated) and ofl_cnt=16'd35000.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 16-bit ALU and its downstream result queue.
//   ALU_W        : ALU data width
//   alu_result_t : one ALU result with its overflow and zero flags
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_W = 16;

   typedef struct packed {
      logic [ALU_W-1:0] data;
      logic             ofl;
      logic             zero;
   } alu_result_t;

endpackage

// File: rtl/alu_result_mem.sv
// ---------------------------------------------------------------------------
// alu_result_mem
// DEPTH-entry register array of alu_result_t with one synchronous write port
// and one asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk      : clock, write happens on the rising edge
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : entry to store
//   rd_addr  : read address
//   rd_data  : entry at rd_addr, combinational
// ---------------------------------------------------------------------------
module alu_result_mem
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  alu_result_t   wr_data,
   input  logic [AW-1:0] rd_addr,
   output alu_result_t   rd_data
);

   alu_result_t mem_q [DEPTH];

   // Storage is intentionally left unreset; validity is tracked by the
   // pointers and count in the parent.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu_result_queue.sv
// ---------------------------------------------------------------------------
// alu_result_queue
// In-order FIFO buffering ALU results (Out, OFL, Zero) for the writeback
// side, with a valid/ready handshake on both sides and a sticky overflow flag.
// Optional statistics counters are enabled by defining the macro
// ALU_RESULT_QUEUE_STATS_EN.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid/in_ready           : upstream handshake (in_ready = !full)
//   in_data/in_ofl/in_zero      : ALU result and flags
//   out_valid/out_ready         : downstream handshake (out_valid = !empty)
//   out_data/out_ofl/out_zero   : head entry, read combinationally
//   count, full, empty          : occupancy status
//   ofl_sticky/clr_sticky       : sticky overflow indicator and its clear
//   push_cnt, ofl_cnt           : (STATS_EN only) saturating 16-bit counters
// ---------------------------------------------------------------------------
module alu_result_queue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ALU_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_data,
   input  logic                     in_ofl,
   input  logic                     in_zero,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_data,
   output logic                     out_ofl,
   output logic                     out_zero,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   input  logic                     clr_sticky,
   output logic                     ofl_sticky
`ifdef ALU_RESULT_QUEUE_STATS_EN
   ,
   output logic [15:0]              push_cnt,
   output logic [15:0]              ofl_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ofl_sticky_q, ofl_sticky_d;
   logic          push, pop;
   alu_result_t   wr_entry;
   alu_result_t   rd_entry;

   // All handshake/status outputs depend only on the count register, so
   // there is no combinational path from in_valid or out_ready.
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = count_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      wr_entry      = '0;
      wr_entry.data = in_data;
      wr_entry.ofl  = in_ofl;
      wr_entry.zero = in_zero;
   end

   // Writes are suppressed in the reset cycle so a push there leaves no trace.
   alu_result_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push && rst_n),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_entry)
   );

   assign out_data = rd_entry.data;
   assign out_ofl  = rd_entry.ofl;
   assign out_zero = rd_entry.zero;

   // DEPTH is a power of two, so plain pointer overflow gives modulo-DEPTH
   // wrap; occupancy comes from count rather than a pointer wrap bit.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Clear first, then a same-cycle accepted overflow result sets it again.
   always_comb begin
      ofl_sticky_d = ofl_sticky_q;
      if (clr_sticky) begin
         ofl_sticky_d = 1'b0;
      end
      if (push && in_ofl) begin
         ofl_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         ofl_sticky_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         ofl_sticky_q <= ofl_sticky_d;
      end
   end

   assign ofl_sticky = ofl_sticky_q;

`ifdef ALU_RESULT_QUEUE_STATS_EN
   logic [15:0] push_cnt_q, push_cnt_d;
   logic [15:0] ofl_cnt_q, ofl_cnt_d;

   // Saturating counters of accepted pushes; clr_sticky does not touch them.
   always_comb begin
      push_cnt_d = push_cnt_q;
      ofl_cnt_d  = ofl_cnt_q;
      if (push && (push_cnt_q != 16'hFFFF)) begin
         push_cnt_d = push_cnt_q + 16'd1;
      end
      if (push && in_ofl && (ofl_cnt_q != 16'hFFFF)) begin
         ofl_cnt_d = ofl_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         push_cnt_q <= '0;
         ofl_cnt_q  <= '0;
      end else begin
         push_cnt_q <= push_cnt_d;
         ofl_cnt_q  <= ofl_cnt_d;
      end
   end

   assign push_cnt = push_cnt_q;
   assign ofl_cnt  = ofl_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_result_queue
// Self-checking bench for alu_result_queue (DEPTH=4, W=16). Expected entries
// are queued in a scoreboard when a push is accepted by the bench's own
// occupancy model and compared against the head when a pop occurs.
// Define ALU_RESULT_QUEUE_STATS_EN to also exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_alu_result_queue;
   import alu_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_ofl;
   logic        in_zero;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_ofl;
   logic        out_zero;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        clr_sticky;
   logic        ofl_sticky;
`ifdef ALU_RESULT_QUEUE_STATS_EN
   logic [15:0] push_cnt;
   logic [15:0] ofl_cnt;
`endif

   int          total = 0;
   int          bad   = 0;

   alu_result_t sb [$];
   int          mdl_cnt;
   logic        mdl_sticky;
   int          mdl_push;
   int          mdl_ofl;

   always #5 clk = ~clk;

   alu_result_queue #(
      .DEPTH (DEPTH),
      .W     (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_ofl     (in_ofl),
      .in_zero    (in_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ofl    (out_ofl),
      .out_zero   (out_zero),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .clr_sticky (clr_sticky),
      .ofl_sticky (ofl_sticky)
`ifdef ALU_RESULT_QUEUE_STATS_EN
      ,
      .push_cnt   (push_cnt),
      .ofl_cnt    (ofl_cnt)
`endif
   );

   // Drives one clock cycle of stimulus and advances the reference model.
   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic drive(input logic v, input logic [15:0] d, input logic o,
                        input logic z, input logic rdy, input logic clr);
      logic        acc;
      logic        pp;
      alu_result_t e;
      in_valid   = v;
      in_data    = d;
      in_ofl     = o;
      in_zero    = z;
      out_ready  = rdy;
      clr_sticky = clr;
      acc = v && (mdl_cnt < DEPTH);
      pp  = rdy && (mdl_cnt > 0);
      if (clr) mdl_sticky = 1'b0;
      if (acc && o) mdl_sticky = 1'b1;
      if (acc) begin
         if (mdl_push < 65535) mdl_push++;
         if (o && mdl_ofl < 65535) mdl_ofl++;
      end
      if (pp) void'(sb.pop_front());
      if (acc) begin
         e.data = d;
         e.ofl  = o;
         e.zero = z;
         sb.push_back(e);
      end
      mdl_cnt = mdl_cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_model();
      sb.delete();
      mdl_cnt    = 0;
      mdl_sticky = 1'b0;
      mdl_push   = 0;
      mdl_ofl    = 0;
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      in_data    = '0;
      in_ofl     = 1'b0;
      in_zero    = 1'b0;
      out_ready  = 1'b0;
      clr_sticky = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_model();
      total++; if (count !== 3'd0)    begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
      total++; if (empty !== 1'b1)    begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
      total++; if (full !== 1'b0)     begin bad++; $display("[TB] FAIL reset_full: got %b want 0", full); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (ofl_sticky !== 1'b0) begin bad++; $display("[TB] FAIL reset_sticky: got %b want 0", ofl_sticky); end
   endtask

   task automatic test_order();
      alu_result_t e;
      drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_inputs();
      total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL order_count: got %0d want 3", count); end
      total++; if (out_data !== 16'h0001) begin bad++; $display("[TB] FAIL order_head: got %h want 0001", out_data); end
      while (mdl_cnt > 0) begin
         e = sb[0];
         total++;
         if ({out_valid, out_data, out_ofl, out_zero} !== {1'b1, e.data, e.ofl, e.zero}) begin
            bad++;
            $display("[TB] FAIL order_pop: got v=%b %h o=%b z=%b want v=1 %h o=%b z=%b",
                     out_valid, out_data, out_ofl, out_zero, e.data, e.ofl, e.zero);
         end
         drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      idle_inputs();
      total++; if (ofl_sticky !== 1'b1) begin bad++; $display("[TB] FAIL order_sticky: got %b want 1", ofl_sticky); end
      total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL order_empty: got %b want 1", empty); end
   endtask

   task automatic test_fill();
      alu_result_t e;
      for (int i = 0; i < 4; i++) drive(1'b1, 16'hA0A0 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      idle_inputs();
      total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got %b want 1", full); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_in_ready: got %b want 0", in_ready); end
      // Push into full queue with a same-cycle pop: the push must be rejected.
      e = sb[0];
      total++;
      if (out_data !== e.data) begin bad++; $display("[TB] FAIL fill_head: got %h want %h", out_data, e.data); end
      drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      idle_inputs();
      total++; if (count !== 3'(mdl_cnt)) begin bad++; $display("[TB] FAIL fill_reject_count: got %0d want %0d", count, mdl_cnt); end
      while (mdl_cnt > 0) begin
         e = sb[0];
         total++;
         if ({out_valid, out_data} !== {1'b1, e.data}) begin
            bad++;
            $display("[TB] FAIL fill_drain: got v=%b %h want v=1 %h", out_valid, out_data, e.data);
         end
         drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      idle_inputs();
      total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL fill_empty: got %b want 1", empty); end
   endtask

   task automatic test_back_to_back();
      alu_result_t e;
      drive(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         e = sb[0];
         total++;
         if ({out_valid, out_data} !== {1'b1, e.data}) begin
            bad++;
            $display("[TB] FAIL b2b_data: got v=%b %0d want v=1 %0d", out_valid, out_data, e.data);
         end
         drive(1'b1, 16'(i), 1'b0, (i == 0), 1'b1, 1'b0);
         total++;
         if (count !== 3'd1) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 1", count); end
      end
      e = sb[0];
      total++;
      if (out_data !== e.data) begin bad++; $display("[TB] FAIL b2b_last: got %0d want %0d", out_data, e.data); end
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle_inputs();
   endtask

   task automatic test_sticky();
      alu_result_t e;
      drive(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
      total++; if (ofl_sticky !== mdl_sticky) begin bad++; $display("[TB] FAIL sticky_set_wins: got %b want %b", ofl_sticky, mdl_sticky); end
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (ofl_sticky !== mdl_sticky) begin bad++; $display("[TB] FAIL sticky_clear: got %b want %b", ofl_sticky, mdl_sticky); end
      for (int i = 0; i < 3; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_inputs();
      total++; if (ofl_sticky !== 1'b0) begin bad++; $display("[TB] FAIL sticky_rejected: got %b want 0", ofl_sticky); end
      total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL sticky_count: got %0d want 4", count); end
      while (mdl_cnt > 0) begin
         e = sb[0];
         total++;
         if ({out_data, out_ofl} !== {e.data, e.ofl}) begin
            bad++;
            $display("[TB] FAIL sticky_drain: got %h o=%b want %h o=%b", out_data, out_ofl, e.data, e.ofl);
         end
         drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive(1'b1, 16'h0C00 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (ofl_sticky !== 1'b1) begin bad++; $display("[TB] FAIL rmid_pre_sticky: got %b want 1", ofl_sticky); end
      in_valid  = 1'b1;
      in_data   = 16'h5555;
      in_ofl    = 1'b1;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_inputs();
      reset_model();
      total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL rmid_count: got %0d want 0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL rmid_empty: got %b want 1", empty); end
      total++; if (ofl_sticky !== 1'b0) begin bad++; $display("[TB] FAIL rmid_sticky: got %b want 0", ofl_sticky); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_out_valid: got %b want 0", out_valid); end
   endtask

`ifdef ALU_RESULT_QUEUE_STATS_EN
   task automatic test_stats();
      total++; if (push_cnt !== 16'd0) begin bad++; $display("[TB] FAIL stats_reset_push: got %0d want 0", push_cnt); end
      for (int i = 0; i < 70000; i++) begin
         drive(1'b1, 16'(i), (i % 2 == 1), 1'b0, 1'b1, (i % 7 == 0));
      end
      idle_inputs();
      total++; if (push_cnt !== 16'(mdl_push)) begin bad++; $display("[TB] FAIL stats_push_cnt: got %h want %h", push_cnt, 16'(mdl_push)); end
      total++; if (ofl_cnt !== 16'(mdl_ofl)) begin bad++; $display("[TB] FAIL stats_ofl_cnt: got %0d want %0d", ofl_cnt, mdl_ofl); end
      total++; if (push_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL stats_saturate: got %h want ffff", push_cnt); end
      total++; if (ofl_cnt !== 16'd35000) begin bad++; $display("[TB] FAIL stats_ofl_35000: got %0d want 35000", ofl_cnt); end
   endtask
`endif

   initial begin
      reset_model();
      test_reset();
      test_order();
      test_fill();
      test_back_to_back();
      test_sticky();
      test_reset_mid();
`ifdef ALU_RESULT_QUEUE_STATS_EN
      test_reset();
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
